deemph_iir: RTL and testbench



---
 rtl/deemph_iir_pkg.sv | 41 ++++
 rtl/deemph_iir_mac.sv | 39 +++
 rtl/deemph_iir.sv | 87 ++++++++
 tb/tb_deemph_iir.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/deemph_iir_pkg.sv
// Shared constants, FSM encoding and dequantiser for the de-emphasis IIR.
// Optional clamp of the dequantised result: DEEMPH_IIR_SATURATE_EN.
package deemph_iir_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BITS       = 10;
    localparam int ACC_W      = 2 * DATA_WIDTH + 2;

    localparam int X0_DEF = 178;
    localparam int X1_DEF = 178;
    localparam int Y1_DEF = 651;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Arithmetic shift floors toward -inf, so negative inputs round down.
    function automatic logic signed [DATA_WIDTH-1:0] dequantize(
        input logic signed [ACC_W-1:0] acc,
        input int                      shift
    );
        logic signed [ACC_W-1:0] s;
        s = acc >>> shift;
`ifdef DEEMPH_IIR_SATURATE_EN
        if (s > Y_MAX) begin
            s = Y_MAX;
        end else if (s < Y_MIN) begin
            s = Y_MIN;
        end
`endif
        return s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/deemph_iir_mac.sv
// Combinational three-term multiply-accumulate for the de-emphasis IIR.
// Samples and coefficients are widened to the accumulator before multiplying.
module iir_mac #(
    parameter int DATA_WIDTH = deemph_iir_pkg::DATA_WIDTH,
    parameter int ACC_W      = 2 * DATA_WIDTH + 2,
    parameter int X0         = deemph_iir_pkg::X0_DEF,
    parameter int X1         = deemph_iir_pkg::X1_DEF,
    parameter int Y1         = deemph_iir_pkg::Y1_DEF
) (
    input  logic signed [DATA_WIDTH-1:0] i_x_cur,
    input  logic signed [DATA_WIDTH-1:0] i_x_prev,
    input  logic signed [DATA_WIDTH-1:0] i_y_prev,
    output logic signed [ACC_W-1:0]      o_acc
);

    localparam int PAD = ACC_W - DATA_WIDTH;

    localparam logic signed [ACC_W-1:0] C_X0 = ACC_W'(X0);
    localparam logic signed [ACC_W-1:0] C_X1 = ACC_W'(X1);
    localparam logic signed [ACC_W-1:0] C_Y1 = ACC_W'(Y1);

    logic signed [ACC_W-1:0] w_xc;
    logic signed [ACC_W-1:0] w_xp;
    logic signed [ACC_W-1:0] w_yp;
    logic signed [ACC_W-1:0] w_p0;
    logic signed [ACC_W-1:0] w_p1;
    logic signed [ACC_W-1:0] w_p2;

    assign w_xc = {{PAD{i_x_cur[DATA_WIDTH-1]}}, i_x_cur};
    assign w_xp = {{PAD{i_x_prev[DATA_WIDTH-1]}}, i_x_prev};
    assign w_yp = {{PAD{i_y_prev[DATA_WIDTH-1]}}, i_y_prev};

    assign w_p0 = C_X0 * w_xc;
    assign w_p1 = C_X1 * w_xp;
    assign w_p2 = C_Y1 * w_yp;

    assign o_acc = w_p0 + w_p1 + w_p2;

endmodule

// File: rtl/deemph_iir.sv
// First-order fixed-point de-emphasis IIR between two FWFT FIFOs.
// Define DEEMPH_IIR_SATURATE_EN to clamp instead of wrap on overflow.
module deemph_iir #(
    parameter int DATA_WIDTH = deemph_iir_pkg::DATA_WIDTH,
    parameter int BITS       = deemph_iir_pkg::BITS,
    parameter int X0         = deemph_iir_pkg::X0_DEF,
    parameter int X1         = deemph_iir_pkg::X1_DEF,
    parameter int Y1         = deemph_iir_pkg::Y1_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din
);

    import deemph_iir_pkg::*;

    localparam int ACC_W = 2 * DATA_WIDTH + 2;

    state_t r_state;

    logic signed [DATA_WIDTH-1:0] r_x_cur;
    logic signed [DATA_WIDTH-1:0] r_x_prev;
    logic signed [DATA_WIDTH-1:0] r_y_prev;
    logic signed [DATA_WIDTH-1:0] r_y;

    logic signed [ACC_W-1:0] w_acc;
    logic                    w_take;
    logic                    w_give;

    // reset is active-low; it gates both handshakes directly.
    assign w_take = reset && (r_state == S_IDLE) && !in_empty;
    assign w_give = reset && (r_state == S_WRITE) && !out_full;

    assign in_rd_en  = w_take;
    assign out_wr_en = w_give;
    assign out_din   = r_y;

    iir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (ACC_W),
        .X0         (X0),
        .X1         (X1),
        .Y1         (Y1)
    ) u_mac (
        .i_x_cur  (r_x_cur),
        .i_x_prev (r_x_prev),
        .i_y_prev (r_y_prev),
        .o_acc    (w_acc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_x_cur  <= '0;
            r_x_prev <= '0;
            r_y_prev <= '0;
            r_y      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_x_cur <= in_dout;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_y     <= dequantize(w_acc, BITS);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_give) begin
                        r_x_prev <= r_x_cur;
                        r_y_prev <= r_y;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deemph_iir.sv
// Directed bench for deemph_iir: impulses, back-pressure, reset, overflow.
// A second instance with overridden coefficients runs in lockstep.
module tb_deemph_iir;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_empty;
    logic        out_full;
    logic [31:0] in_dout;
    logic        in_rd_en;
    logic        out_wr_en;
    logic [31:0] out_din;
    logic        ov_rd_en;
    logic        ov_wr_en;
    logic [31:0] ov_din;

    int n_err = 0;
    int n_chk = 0;

    always #5 clock = ~clock;

    deemph_iir u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_din   (out_din)
    );

    deemph_iir #(
        .X0 (1024),
        .X1 (1024),
        .Y1 (0)
    ) u_ovf (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (ov_rd_en),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .out_wr_en (ov_wr_en),
        .out_full  (out_full),
        .out_din   (ov_din)
    );

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_empty = 1'b1;
        out_full = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Present one sample, wait for the read and the write, return outputs.
    task automatic xfer(input string tag, input logic signed [31:0] x,
                        output logic signed [31:0] y,
                        output logic signed [31:0] yo);
        int  k;
        bit  seen;
        @(posedge clock);
        #1;
        in_dout  = x;
        in_empty = 1'b0;
        seen = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (in_rd_en) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_rd_wait"}, longint'(k), 0);
        check({tag, "_ov_rd"}, longint'(ov_rd_en), 1);
        @(posedge clock);
        #1;
        in_empty = 1'b1;
        seen = 1'b0;
        for (k = 1; k < 200; k++) begin
            @(negedge clock);
            if (out_wr_en) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_lat"}, seen ? longint'(k) : -1, 2);
        y  = out_din;
        yo = ov_din;
    endtask

    logic signed [31:0] y;
    logic signed [31:0] yo;
    longint             m_xp;
    longint             m_yp;
    longint             m_x;
    longint             m_acc;
    longint             m_y;

    initial begin
        reset    = 1'b0;
        in_empty = 1'b0;
        out_full = 1'b0;
        in_dout  = 32'd1024;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rd_en", longint'(in_rd_en), 0);
        check("rst_wr_en", longint'(out_wr_en), 0);
        check("rst_din", longint'(out_din), 0);
        #1;
        reset    = 1'b1;
        in_empty = 1'b1;

        xfer("imp0", 1024, y, yo);
        check("imp0", longint'(y), 178);
        xfer("imp1", 0, y, yo);
        check("imp1", longint'(y), 291);
        xfer("imp2", 0, y, yo);
        check("imp2", longint'(y), 185);

        do_reset();
        xfer("neg0", -1024, y, yo);
        check("neg0", longint'(y), -178);
        xfer("neg1", 0, y, yo);
        check("neg1", longint'(y), -292);

        // Back-pressure: stall 10 cycles with a new sample waiting upstream.
        do_reset();
        @(posedge clock);
        #1;
        out_full = 1'b1;
        in_dout  = 32'd1024;
        in_empty = 1'b0;
        @(negedge clock);
        check("bp_rd", longint'(in_rd_en), 1);
        @(posedge clock);
        #1;
        in_dout = 32'd0;
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_wr_en", longint'(out_wr_en), 0);
            check("bp_rd_en", longint'(in_rd_en), 0);
            check("bp_din", longint'($signed(out_din)), 178);
        end
        @(posedge clock);
        #1;
        out_full = 1'b0;
        @(negedge clock);
        check("bp_rel_wr", longint'(out_wr_en), 1);
        check("bp_rel_din", longint'($signed(out_din)), 178);
        xfer("bp_next", 0, y, yo);
        check("bp_next", longint'(y), 291);

        // Reset while the impulse is in S_MAC.
        do_reset();
        @(posedge clock);
        #1;
        in_dout  = 32'd1024;
        in_empty = 1'b0;
        @(negedge clock);
        check("mr_rd", longint'(in_rd_en), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("mr_wr_en", longint'(out_wr_en), 0);
            check("mr_rd_en", longint'(in_rd_en), 0);
        end
        @(posedge clock);
        #1;
        reset    = 1'b1;
        in_empty = 1'b1;
        xfer("mr_after", 0, y, yo);
        check("mr_after", longint'(y), 0);

        // Overflow on the overridden instance.
        do_reset();
        xfer("ovf0", 32'sh7fffffff, y, yo);
        check("ovf0", longint'(yo), 2147483647);
        xfer("ovf1", 32'sh7fffffff, y, yo);
`ifdef DEEMPH_IIR_SATURATE_EN
        check("ovf1", longint'(yo), 2147483647);
`else
        check("ovf1", longint'(yo), -2);
`endif

        // Short random stream against a floor-rounding reference.
        do_reset();
        m_xp = 0;
        m_yp = 0;
        for (int i = 0; i < 40; i++) begin
            m_x   = longint'($urandom_range(0, 33554431)) - 16777216;
            m_acc = 178 * m_x + 178 * m_xp + 651 * m_yp;
            m_y   = m_acc >>> 10;
            xfer("stream", 32'(m_x), y, yo);
            check("stream", longint'(y), m_y);
            m_xp = m_x;
            m_yp = m_y;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
